// File: rtl/crc_serial_engine.sv
// Bit-serial CRC fold of a 1..8 byte word into a 1..CRC_MAX_WIDTH bit CRC, MSB first.
// Latency nbits+1 cycles from start to done; start while busy is dropped, not queued.
module crc_serial_engine #(
    parameter int CRC_MAX_WIDTH = 32,
    parameter int DATA_BITS     = 64
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_start,
    input  logic [DATA_BITS-1:0]             i_data_in,
    input  logic [$clog2(DATA_BITS/8)-1:0]   i_bytewidth,
    input  logic [CRC_MAX_WIDTH-1:0]         i_poly,
    input  logic [$clog2(CRC_MAX_WIDTH)-1:0] i_width_m1,
    input  logic [CRC_MAX_WIDTH-1:0]         i_crc_seed,
    output logic                             o_busy,
    output logic                             o_done,
    output logic [CRC_MAX_WIDTH-1:0]         o_crc_out
);

    localparam int CW = $clog2(DATA_BITS);
    localparam int WW = $clog2(CRC_MAX_WIDTH);
    localparam logic [CRC_MAX_WIDTH-1:0] ONES = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                   r_state;
    logic [DATA_BITS-1:0]     r_data;
    logic [CW-1:0]            r_last;
    logic [CW-1:0]            r_count;
    logic [WW-1:0]            r_width_m1;
    logic [CRC_MAX_WIDTH-1:0] r_mask;
    logic [CRC_MAX_WIDTH-1:0] r_poly;
    logic [CRC_MAX_WIDTH-1:0] r_crc;
    logic [CRC_MAX_WIDTH-1:0] r_crc_out;
    logic                     r_busy;
    logic                     r_done;

    logic [CRC_MAX_WIDTH-1:0] w_mask;
    logic [CW-1:0]            w_align;
    logic                     w_fb;
    logic [CRC_MAX_WIDTH-1:0] w_crc_next;

    // Double shift keeps width_m1 = max legal (all ones) from overflowing the shift.
    assign w_mask = ~((ONES << i_width_m1) << 1);

    // Left-align the active bytes so the next data bit is always the word MSB;
    // unused upper bits fall off the top before they are ever looked at.
    assign w_align = {~i_bytewidth, 3'b000};

    assign w_fb       = r_crc[r_width_m1] ^ r_data[DATA_BITS-1];
    assign w_crc_next = ((r_crc << 1) & r_mask) ^ (w_fb ? r_poly : '0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_data     <= '0;
            r_last     <= '0;
            r_count    <= '0;
            r_width_m1 <= '0;
            r_mask     <= '0;
            r_poly     <= '0;
            r_crc      <= '0;
            r_crc_out  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_data     <= i_data_in << w_align;
                        r_last     <= {i_bytewidth, 3'b111};
                        r_width_m1 <= i_width_m1;
                        r_mask     <= w_mask;
                        r_poly     <= i_poly & w_mask;
                        r_crc      <= i_crc_seed & w_mask;
                        r_count    <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_crc   <= w_crc_next;
                    r_data  <= r_data << 1;
                    r_count <= r_count + 1'b1;
                    if (r_count == r_last) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_crc_out <= r_crc;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_crc_out = r_crc_out;

endmodule

// File: doc/crc_serial_engine.md
Name: crc_serial_engine

Overview:
- Bit-serial CRC engine that sits directly downstream of the byte-reflection stage.
- It consumes the packed, zero-extended data word, 1 to 8 bytes wide, and folds it into a programmable CRC of width 1..CRC_MAX_WIDTH, one bit per clock, MSB first.
- The result is held for readback and can be fed back as the next seed, so messages longer than 8 bytes are handled by chaining.
- Output reflection and final XOR are handled outside this block.

Parameters:
- CRC_MAX_WIDTH, 32, maximum CRC register width in bits.
- DATA_BITS, 64, width of the packed data word; equals 8 × maximum bytes.

Ports:
- clk  input  1  system clock.
- reset  input  1  reset.
- start  input  1  request to begin one fold; sampled only in IDLE.
- data_in  input  64  packed data word. Only bits [nbits-1:0] are used; bit nbits-1 is processed first.
- bytewidth  input  3  number of data bytes minus one: 0 means 1 byte, 7 means 8 bytes.
- poly  input  32  generator polynomial, implicit top bit omitted, right-aligned.
- width_m1  input  5  CRC width minus one: 7 means CRC-8, 31 means CRC-32.
- crc_seed  input  32  initial CRC register value, right-aligned.
- busy  output  1  high while a fold is in progress.
- done  output  1  one-cycle pulse when crc_out is updated.
- crc_out  output  32  result, right-aligned; bits above width_m1 are zero.

Behaviour:
- Reset: one clock, synchronous, active-high. Reset drives state to IDLE, busy=0, done=0, crc_out=0, bit counter=0, and clears all internal registers.
- Reset asserted mid-fold: the fold is abandoned, no done pulse is produced, and crc_out is cleared to 0.
- States are IDLE, SHIFT and DONE.
- IDLE, with start=1:
  - latch data_in, bytewidth, poly, width_m1;
  - set nbits = (bytewidth+1)*8;
  - load crc = crc_seed & mask, where mask = (2^(width_m1+1))-1;
  - clear the counter and go to SHIFT.
- IDLE, with start=0: stay in IDLE.
- Inputs are latched on the start cycle only. Changes to any input during SHIFT or DONE are ignored.
- SHIFT, once per cycle:
  - d = data[nbits-1-count];
  - fb = crc[width_m1] ^ d;
  - crc = ((crc<<1) & mask) ^ (fb ? (poly & mask) : 0);
  - count = count+1.
- Leave SHIFT for DONE after the cycle that processes count = nbits-1.
- DONE lasts one cycle: crc_out <= crc, done=1, then return to IDLE.
- busy=1 in SHIFT and DONE, 0 in IDLE.
- Latency: with start sampled at edge 0, busy rises after edge 0. crc_out and done are valid after edge nbits+1, so 9 cycles for 1 byte and 65 cycles for 8 bytes.
- A new start is accepted on the cycle after done, i.e. back in IDLE. Start asserted while busy is ignored, not queued.
- crc_out holds its value from the last completed fold until the next DONE or a reset.
- Width rules:
  - poly and seed bits above width_m1 are ignored.
  - width_m1=0 (CRC-1, parity) is legal.
  - Widths above CRC_MAX_WIDTH are not representable on the port.
- bytewidth is 3 bits, so all 8 values are legal and there is no error case.
- Chaining: driving crc_seed from crc_out with a new start yields the CRC of the concatenated message.

Test Plan:
1. Single byte: reset, then start with width_m1=7, poly=0x07, seed=0x00, data_in=0x01, bytewidth=0.
   - Required: done pulses exactly 9 cycles after start; crc_out=0x07.
   - Repeat with data_in=0x00: crc_out=0x00.
2. Chaining, CRC-8 (poly 0x07, seed 0):
   - fold data_in=0x3132333435363738, bytewidth=7;
   - then fold data_in=0x39, bytewidth=0, seed=crc_out;
   - required: final crc_out=0xF4, first done 65 cycles after start.
3. CRC-16/XMODEM: width_m1=15, poly=0x1021, seed=0. Fold "12345678" then chain "9". Required: crc_out=0x31C3.
4. CRC-32/MPEG-2: width_m1=31, poly=0x04C11DB7, seed=0xFFFFFFFF. Fold "12345678" then chain "9". Required: crc_out=0x0376E6E7.
5. Ignore rules:
   - Pulse start again mid-fold, change data_in, and set upper data_in bits above nbits to garbage.
   - Required: the result is identical to scenario 1 and there is only one done pulse.
   - Seed 0xFFFFFF00 with width_m1=7 behaves as seed 0x00.
6. Reset mid-fold: assert reset at count=20 of an 8-byte fold.
   - Required: busy=0, crc_out=0, no done pulse.
   - A start on the cycle after reset releases runs to a correct result.
